rgb2gray_stream: RTL and testbench
==================================

Name: rgb2gray_stream

Overview:
AXI4-Stream stage that converts 24-bit RGB pixels to 8-bit luma. It sits directly upstream of the sharpen stage and feeds its 8-bit stream.
It also tracks pixel and line position against the frame geometry and flags tlast framing errors.
It is fully pipelined at one pixel per clock, with a skid buffer on the input for registered back-pressure.

Parameters:
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_axis_tdata  in  24  pixel {R[23:16], G[15:8], B[7:0]}
s_axis_tkeep  in  3  byte enables
s_axis_tlast  in  1  end of frame
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready (registered)
m_axis_tdata  out  8  luma Y
m_axis_tkeep  out  1  AND-reduction of the three input keep bits
m_axis_tlast  out  1  end of frame
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
frame_done  out  1  1-cycle pulse when the last-pixel beat is accepted at the output
err_tlast_early  out  1  sticky: tlast seen before the last pixel of the frame
err_tlast_late  out  1  sticky: last pixel of the frame seen without tlast

Behaviour:
- Reset, synchronous on rstn=0. All of the following reset to 0: every output, skid buffer, pipeline valids, counters.
- s_axis_tready rises the first cycle after reset is released.
- Input skid buffer, 2 entries:
  - Transparent when empty.
  - s_axis_tready is registered and equals "skid holding register empty".
  - When the pipeline stalls while a beat is being accepted, that beat is captured in the holding register.
  - The holding register drains first when the stall clears.
  - No beat is dropped or duplicated under any tvalid/tready pattern.
- Pipeline advance: adv = !m_axis_tvalid || m_axis_tready. All stages hold when adv=0.
- Stage 1 register:
  - pr = 77*R, pg = 150*G, pb = 29*B, each 16 bits unsigned.
  - keep, tlast and a last-pixel flag are carried alongside.
- Stage 2 (output register): Y = (pr + pg + pb + RND) >> 8.
  - Sum held at 17 bits.
  - RND = 0 by default, so the result is truncated.
  - Maximum result is 255; no saturation is needed.
- Latency: a beat accepted on edge N is presented on m_axis_* after edge N+2 when there is no stall.
- Output beats stay stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI rule).
- Position counters:
  - pix_cnt has $clog2(WIDTH) bits; line_cnt has $clog2(HEIGHT) bits.
  - Both advance on each beat leaving the skid buffer into stage 1.
  - pix_cnt wraps at WIDTH-1 and then increments line_cnt.
  - last_pix = (pix_cnt==WIDTH-1 && line_cnt==HEIGHT-1).
- Framing:
  - tlast on a beat with last_pix=0: set err_tlast_early and clear both counters (resync to the next beat as pixel 0,0).
  - last_pix=1 without tlast: set err_tlast_late; counters wrap to 0 normally.
  - Error flags clear only on reset.
- m_axis_tlast is passed through from the input beat by default.
- frame_done pulses for 1 cycle on the output handshake of a beat with last_pix=1.
- Reset mid-frame: pipeline contents are discarded, counters return to 0, and no output beat appears until new input arrives.

Optional Feature:
RGB2GRAY_TLAST_REGEN_EN
- Defined:
  - m_axis_tlast is driven from the last_pix flag, ignoring s_axis_tlast.
  - Error flags are still computed.
  - Early tlast no longer resyncs the counters.
- Undefined: tlast passthrough and resync-on-early-tlast exactly as above.

Decomposition:
- Shared package img_pkg:
  - IMG_WIDTH=640, IMG_HEIGHT=480.
  - Luma coefficients COEF_R=77, COEF_G=150, COEF_B=29.
  - Pixel typedefs rgb_t (24b) and gray_t (8b).
- Sub-module axis_skid_buffer, parameterised on data width; carries tdata+tkeep+tlast.
- Parent contains the counters, the arithmetic pipeline and the error logic.

Test Plan:
- Single beats with m_axis_tready=1:
  - 0xFF0000 -> Y=0x4C
  - 0x00FF00 -> 0x95
  - 0x0000FF -> 0x1C
  - 0xFFFFFF -> 0xFF
  - 0x000000 -> 0x00
  - Each valid 2 cycles after the accept edge.
- Full 640x480 frame streamed with tlast on the final beat:
  - 307200 outputs.
  - tlast only on the last one.
  - frame_done pulses once.
  - No error flags set.
- Random tvalid and m_axis_tready (50% each) over 2 frames of a ramp pattern:
  - Output sequence equals the reference model.
  - No drops or duplicates.
  - tdata is stable during stalls.
- tlast asserted on pixel 100 of line 0:
  - err_tlast_early=1.
  - The next beat is counted as (0,0); a following clean frame sets no new frame_done error.
- Frame with tlast omitted: err_tlast_late=1 on the last pixel, and frame_done still pulses.
- rstn pulled low for 1 cycle mid-frame with beats in flight:
  - All outputs return to 0.
  - s_axis_tready returns to 1 the next cycle.
  - The following frame completes cleanly.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default frame geometry, BT.601-style
// luma coefficients (8-bit fixed point) and pixel types.
package img_pkg;

    localparam int unsigned IMG_WIDTH  = 640;
    localparam int unsigned IMG_HEIGHT = 480;

    // Coefficients sum to 256, so full-scale white maps exactly to 255.
    localparam int unsigned COEF_R   = 77;
    localparam int unsigned COEF_G   = 150;
    localparam int unsigned COEF_B   = 29;
    localparam int unsigned LUMA_RND = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [7:0] gray_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer: an output register plus a holding
// register. s_ready is registered and is high exactly when the holding
// register is empty, so upstream sees no combinational path from m_ready.
module axis_skid_buffer #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned KEEP_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int unsigned BEAT_W = DATA_W + KEEP_W + 1;

    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] hold_beat;
    logic [BEAT_W-1:0] out_beat;
    logic              hold_valid;
    logic              accept;

    assign in_beat = {s_data, s_keep, s_last};
    assign accept  = s_valid && s_ready;
    assign {m_data, m_keep, m_last} = out_beat;

    // Output register loads only when downstream advances; a beat accepted
    // during a stall parks in the holding register and drains first.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid    <= 1'b0;
            out_beat   <= '0;
            hold_valid <= 1'b0;
            hold_beat  <= '0;
            s_ready    <= 1'b0;
        end else if (m_ready) begin
            m_valid    <= hold_valid || accept;
            out_beat   <= hold_valid ? hold_beat : in_beat;
            hold_valid <= 1'b0;
            s_ready    <= 1'b1;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_beat  <= in_beat;
            s_ready    <= 1'b0;
        end else begin
            s_ready    <= !hold_valid;
        end
    end

endmodule

// File: rtl/rgb2gray_stream.sv
// RGB888 -> 8-bit luma AXI4-Stream stage with frame position tracking and
// tlast framing checks. One pixel per clock, 3-cycle pipeline
// (skid output register, product register, sum/output register).
// Build option RGB2GRAY_TLAST_REGEN_EN: output tlast is regenerated from the
// frame position instead of passed through, and early tlast no longer
// resynchronises the position counters.
module rgb2gray_stream
    import img_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned HEIGHT = IMG_HEIGHT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [23:0] s_axis_tdata,
    input  logic [2:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        frame_done,
    output logic        err_tlast_early,
    output logic        err_tlast_late
);

    localparam int unsigned PW = $clog2(WIDTH);
    localparam int unsigned LW = $clog2(HEIGHT);
    localparam logic [PW-1:0] PIX_LAST  = PW'(WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(HEIGHT - 1);

`ifdef RGB2GRAY_TLAST_REGEN_EN
    localparam bit TLAST_REGEN = 1'b1;
`else
    localparam bit TLAST_REGEN = 1'b0;
`endif

    logic [23:0]   sk_data;
    logic [2:0]    sk_keep;
    logic          sk_last;
    logic          sk_valid;
    logic          adv;
    logic          sk_fire;
    rgb_t          px;

    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic          last_pix;
    logic          tlast_early;
    logic          tlast_late;

    logic          s1_valid;
    logic [15:0]   s1_pr;
    logic [15:0]   s1_pg;
    logic [15:0]   s1_pb;
    logic [2:0]    s1_keep;
    logic          s1_last;
    logic          s1_lp;
    logic [16:0]   sum;
    gray_t         y;
    logic          m_lp;

    assign adv     = !m_axis_tvalid || m_axis_tready;
    assign sk_fire = sk_valid && adv;
    assign px      = rgb_t'(sk_data);

    axis_skid_buffer #(
        .DATA_W (24),
        .KEEP_W (3)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  (s_axis_tdata),
        .s_keep  (s_axis_tkeep),
        .s_last  (s_axis_tlast),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (sk_data),
        .m_keep  (sk_keep),
        .m_last  (sk_last),
        .m_valid (sk_valid),
        .m_ready (adv)
    );

    assign last_pix    = (pix_cnt == PIX_LAST) && (line_cnt == LINE_LAST);
    assign tlast_early = sk_last && !last_pix;
    assign tlast_late  = last_pix && !sk_last;

    // Position of the beat entering stage 1; early tlast resyncs to (0,0).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (sk_fire) begin
            if (!TLAST_REGEN && tlast_early) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (pix_cnt == PIX_LAST) begin
                pix_cnt  <= '0;
                line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + LW'(1);
            end else begin
                pix_cnt  <= pix_cnt + PW'(1);
            end
        end
    end

    // Sticky framing error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_tlast_early <= 1'b0;
            err_tlast_late  <= 1'b0;
        end else if (sk_fire) begin
            if (tlast_early) err_tlast_early <= 1'b1;
            if (tlast_late)  err_tlast_late  <= 1'b1;
        end
    end

    // Stage 1: weighted channel products plus sideband.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_pr    <= '0;
            s1_pg    <= '0;
            s1_pb    <= '0;
            s1_keep  <= '0;
            s1_last  <= 1'b0;
            s1_lp    <= 1'b0;
        end else if (adv) begin
            s1_valid <= sk_valid;
            s1_pr    <= 16'(COEF_R) * 16'(px.r);
            s1_pg    <= 16'(COEF_G) * 16'(px.g);
            s1_pb    <= 16'(COEF_B) * 16'(px.b);
            s1_keep  <= sk_keep;
            s1_last  <= TLAST_REGEN ? last_pix : sk_last;
            s1_lp    <= last_pix;
        end
    end

    assign sum = 17'(s1_pr) + 17'(s1_pg) + 17'(s1_pb) + 17'(LUMA_RND);
    assign y   = 8'(sum >> 8);

    // Stage 2: output register, held while the sink stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_lp          <= 1'b0;
        end else if (adv) begin
            m_axis_tvalid <= s1_valid;
            m_axis_tdata  <= y;
            m_axis_tkeep  <= &s1_keep;
            m_axis_tlast  <= s1_last;
            m_lp          <= s1_lp;
        end
    end

    // One-cycle pulse after the last pixel of a frame handshakes out.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= m_axis_tvalid && m_axis_tready && m_lp;
        end
    end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Self-checking bench for rgb2gray_stream using a reduced 10x3 frame.
module tb_rgb2gray_stream;

    localparam int W  = 10;
    localparam int H  = 3;
    localparam int FP = W * H;

`ifdef RGB2GRAY_TLAST_REGEN_EN
    localparam bit REGEN = 1'b1;
`else
    localparam bit REGEN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [23:0] s_tdata;
    logic [2:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        frame_done;
    logic        err_early;
    logic        err_late;

    rgb2gray_stream #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tlast    (s_tlast),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tlast    (m_tlast),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .frame_done      (frame_done),
        .err_tlast_early (err_early),
        .err_tlast_late  (err_late)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic       keep;
        logic       last;
    } exp_t;

    typedef struct {
        logic [23:0] d;
        logic [2:0]  k;
        logic [7:0]  y;
        logic        kp;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    int   mp, ml, exp_fd, fd_cnt, out_cnt, last_cnt;
    bit   exp_early, exp_late, prev_stall;
    logic [9:0] prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] luma_ref(input logic [23:0] p);
        int s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return 8'(s / 256);
    endfunction

    function automatic logic [23:0] ramp(input int i);
        return {8'(i * 5), 8'(255 - i * 3), 8'(i * 11)};
    endfunction

    task automatic clear_model();
        q.delete();
        mp = 0; ml = 0;
        exp_fd = 0; fd_cnt = 0; out_cnt = 0; last_cnt = 0;
        exp_early = 1'b0; exp_late = 1'b0; prev_stall = 1'b0;
    endtask

    // Reference framing model applied to each beat accepted at the input.
    task automatic model_push(input logic [23:0] d, input logic [2:0] k, input bit t);
        bit   lp;
        exp_t e;
        lp     = (mp == W - 1) && (ml == H - 1);
        e.y    = luma_ref(d);
        e.keep = &k;
        e.last = REGEN ? lp : t;
        q.push_back(e);
        if (lp) exp_fd++;
        if (t && !lp) exp_early = 1'b1;
        if (lp && !t) exp_late = 1'b1;
        if (!REGEN && t && !lp) begin
            mp = 0; ml = 0;
        end else if (mp == W - 1) begin
            mp = 0;
            ml = (ml == H - 1) ? 0 : ml + 1;
        end else begin
            mp++;
        end
    endtask

    task automatic observe();
        if (frame_done) fd_cnt++;
        if (prev_stall)
            check("stall_hold", {m_tvalid, m_tdata, m_tkeep, m_tlast}, {1'b1, prev_out});
    endtask

    task automatic out_hs();
        exp_t e;
        if (m_tvalid && m_tready) begin
            out_cnt++;
            if (m_tlast) last_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_beat actual=0x%0h required=none at %0t", m_tdata, $time);
            end else begin
                e = q.pop_front();
                check("beat_data", m_tdata, e.y);
                check("beat_keep_last", {m_tkeep, m_tlast}, {e.keep, e.last});
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tdata, m_tkeep, m_tlast};
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        repeat (n) @(negedge clk);
        rstn = 1'b1;
        clear_model();
    endtask

    task automatic run_stream(input int nbeats, input int early_idx, input bit omit_last,
                              input int pv, input int pr, input bit drain);
        int sent = 0;
        int cyc  = 0;
        bit pend = 1'b0;
        while ((sent < nbeats || (drain && q.size() != 0)) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            observe();
            m_tready = ($urandom_range(99) < pr);
            out_hs();
            if (!pend) begin
                if (sent < nbeats && $urandom_range(99) < pv) begin
                    s_tvalid = 1'b1;
                    s_tdata  = ramp(sent);
                    s_tkeep  = (sent % 7 == 3) ? 3'b101 : 3'b111;
                    s_tlast  = (sent == early_idx) || (!omit_last && (sent % FP == FP - 1));
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            if (s_tvalid && s_tready) begin
                model_push(s_tdata, s_tkeep, s_tlast);
                sent++;
                pend = 1'b0;
            end else begin
                pend = s_tvalid;
            end
        end
        check("stream_complete", (sent == nbeats) && (!drain || q.size() == 0), 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            observe();
            m_tready = 1'b1;
            out_hs();
        end
    endtask

    task automatic check_frame(input string tag, input int n_out, input int n_last);
        check({tag, "_outs"}, out_cnt, n_out);
        check({tag, "_lasts"}, last_cnt, n_last);
        check({tag, "_frame_done"}, fd_cnt, exp_fd);
        check({tag, "_err_early"}, err_early, exp_early);
        check({tag, "_err_late"}, err_late, exp_late);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{24'hFF0000, 3'b111, 8'h4C, 1'b1};
        vecs[1] = '{24'h00FF00, 3'b111, 8'h95, 1'b1};
        vecs[2] = '{24'h0000FF, 3'b111, 8'h1C, 1'b1};
        vecs[3] = '{24'hFFFFFF, 3'b111, 8'hFF, 1'b1};
        vecs[4] = '{24'h000000, 3'b111, 8'h00, 1'b1};
        vecs[5] = '{24'h123456, 3'b111, 8'h2D, 1'b1};
        vecs[6] = '{24'h808080, 3'b011, 8'h80, 1'b0};
        vecs[7] = '{24'h010101, 3'b110, 8'h01, 1'b0};

        rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        m_tready = 1'b0;
        clear_model();

        // Reset values and tready rising after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", s_tready, 0);
        check("rst_m_valid", m_tvalid, 0);
        check("rst_m_fields", {m_tdata, m_tkeep, m_tlast}, 0);
        check("rst_flags", {frame_done, err_early, err_late}, 0);
        @(negedge clk);
        rstn = 1'b1;
        check("rel_tready_low", s_tready, 0);
        @(posedge clk);
        #1;
        check("rel_tready_high", s_tready, 1);

        // Single beats: exact latency, data and keep reduction.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1; s_tdata = vecs[i].d; s_tkeep = vecs[i].k; s_tlast = 1'b0;
            m_tready = 1'b1;
            check("vec_tready", s_tready, 1);
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
            check("vec_not_early", m_tvalid, 0);
            @(posedge clk);
            #1;
            check("vec_valid", m_tvalid, 1);
            check("vec_data", m_tdata, vecs[i].y);
            check("vec_keep", m_tkeep, vecs[i].kp);
        end
        check("vec_no_err", {err_early, err_late}, 0);

        // Clean frame at full rate.
        do_reset(2);
        run_stream(FP, -1, 1'b0, 100, 100, 1'b1);
        settle(4);
        check_frame("full", FP, 1);

        // Two frames with random source and sink throttling.
        do_reset(2);
        run_stream(2 * FP, -1, 1'b0, 50, 50, 1'b1);
        settle(4);
        check_frame("rand", 2 * FP, 2);
        check("rand_fd_two", fd_cnt, 2);

        // Early tlast on pixel 5 of line 0, then a clean frame.
        do_reset(2);
        run_stream(6, 5, 1'b0, 100, 100, 1'b0);
        run_stream(FP, -1, 1'b0, 100, 100, 1'b1);
        settle(4);
        check("early_flag", err_early, 1);
        check_frame("early", FP + 6, REGEN ? 1 : 2);

        // Frame with tlast omitted.
        do_reset(2);
        run_stream(FP, -1, 1'b1, 100, 100, 1'b1);
        settle(4);
        check("late_flag", err_late, 1);
        check_frame("late", FP, REGEN ? 1 : 0);

        // One-cycle reset mid-frame with beats in flight.
        do_reset(2);
        run_stream(12, -1, 1'b0, 100, 100, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_tready", s_tready, 0);
        check("mid_rst_outs", {m_tvalid, m_tdata, m_tkeep, m_tlast}, 0);
        check("mid_rst_flags", {frame_done, err_early, err_late}, 0);
        @(negedge clk);
        rstn = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        check("mid_rel_tready", s_tready, 1);
        settle(5);
        check("mid_no_ghost", out_cnt, 0);
        run_stream(FP, -1, 1'b0, 100, 100, 1'b1);
        settle(4);
        check_frame("post_rst", FP, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
